// File: rtl/data_ram_if.sv
// CPU-side bus of the jacaranda-8 data memory: address, write port, clear request,
// combinational read data, busy flag and the low-address debug taps.
interface data_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DBG_N  = 2
);
    logic [ADDR_W-1:0]       addr;
    logic [DATA_W-1:0]       w_data;
    logic                    w_en;
    logic                    clr_req;
    logic [DATA_W-1:0]       r_data;
    logic                    busy;
    logic [DBG_N*DATA_W-1:0] dbg_mem;

    modport master (
        output addr, w_data, w_en, clr_req,
        input  r_data, busy, dbg_mem
    );

    modport slave (
        input  addr, w_data, w_en, clr_req,
        output r_data, busy, dbg_mem
    );
endinterface

// File: rtl/data_ram.sv
// Single-port data memory with combinational read, synchronous write and a
// one-word-per-cycle hardware clear sequencer that masks reads while running.
module data_ram #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int DBG_N          = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic       clock,
    input logic       reset,
    data_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_busy = (r_state == S_CLEAR);

    // Clear owns the write port while running; CPU writes are simply dropped.
    // Writes are also blocked while reset is held so the array stays untouched.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus.addr;
        w_wdata = bus.w_data;
        if (!reset) begin
            if (w_busy) begin
                w_we    = 1'b1;
                w_waddr = r_clr_ptr;
                w_wdata = '0;
            end else begin
                w_we    = bus.w_en;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            r_clr_ptr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.clr_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_ptr <= '0;
                    end
                end
                S_CLEAR: begin
                    // Pointer wraps to 0 naturally on the final word.
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == '1) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_clr_ptr <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign bus.busy   = w_busy;
    assign bus.r_data = w_busy ? '0 : r_mem[bus.addr];

    generate
        for (genvar gi = 0; gi < DBG_N; gi++) begin : g_dbg
            assign bus.dbg_mem[gi*DATA_W +: DATA_W] = w_busy ? '0 : r_mem[gi];
        end
    endgenerate
endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: default 256x8 clear-on-reset instance plus a
// 16x16 instance without clear-on-reset.
module tb_data_ram;
    logic clk;
    logic rst_a;
    logic rst_b;

    int checks;
    int errors;

    data_ram_if #(.DATA_W(8),  .ADDR_W(8), .DBG_N(2)) bus_a ();
    data_ram_if #(.DATA_W(16), .ADDR_W(4), .DBG_N(4)) bus_b ();

    data_ram #(
        .DATA_W(8), .ADDR_W(8), .DBG_N(2), .CLEAR_ON_RESET(1'b1)
    ) dut_a (
        .clock(clk),
        .reset(rst_a),
        .bus  (bus_a.slave)
    );

    data_ram #(
        .DATA_W(16), .ADDR_W(4), .DBG_N(4), .CLEAR_ON_RESET(1'b0)
    ) dut_b (
        .clock(clk),
        .reset(rst_b),
        .bus  (bus_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-24s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops; optionally checks r_data stays masked.
    task automatic wait_idle_a(input bit chk_mask, output int n);
        n = 0;
        while (bus_a.busy === 1'b1 && n < 1000) begin
            if (chk_mask && bus_a.r_data !== 8'h00) begin
                chk("a_mask_during_busy", 64'(bus_a.r_data), 64'h0);
            end
            tick();
            n++;
        end
    endtask

    task automatic wait_idle_b(output int n);
        n = 0;
        while (bus_b.busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        bus_a.addr = '0; bus_a.w_data = '0; bus_a.w_en = 1'b0; bus_a.clr_req = 1'b0;
        bus_b.addr = '0; bus_b.w_data = '0; bus_b.w_en = 1'b0; bus_b.clr_req = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();

        // Outputs while reset is held
        chk("a_busy_in_reset",   64'(bus_a.busy),    64'h1);
        chk("a_rdata_in_reset",  64'(bus_a.r_data),  64'h0);
        chk("a_dbg_in_reset",    64'(bus_a.dbg_mem), 64'h0);
        chk("b_busy_in_reset",   64'(bus_b.busy),    64'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Post-reset clear lasts exactly DEPTH edges
        wait_idle_a(1'b1, n);
        chk("a_reset_clear_len", 64'(n), 64'd256);
        bus_a.addr = 8'h00; #1; chk("a_rd_00_after_clr", 64'(bus_a.r_data), 64'h0);
        bus_a.addr = 8'h7F; #1; chk("a_rd_7f_after_clr", 64'(bus_a.r_data), 64'h0);
        bus_a.addr = 8'hFF; #1; chk("a_rd_ff_after_clr", 64'(bus_a.r_data), 64'h0);

        // Write/read, including read-during-write old/new value
        bus_a.addr = 8'h10; bus_a.w_data = 8'hA5; bus_a.w_en = 1'b1; #1;
        chk("a_rdw_old_10", 64'(bus_a.r_data), 64'h00);
        tick();
        chk("a_rd_10", 64'(bus_a.r_data), 64'hA5);
        bus_a.addr = 8'h01; bus_a.w_data = 8'h3C; #1;
        chk("a_rdw_old_01", 64'(bus_a.r_data), 64'h00);
        tick();
        bus_a.w_en = 1'b0;
        chk("a_dbg_tap1", 64'(bus_a.dbg_mem[15:8]), 64'h3C);
        chk("a_dbg_tap0", 64'(bus_a.dbg_mem[7:0]),  64'h00);
        bus_a.addr = 8'h10; #1;
        chk("a_rd_10_again", 64'(bus_a.r_data), 64'hA5);

        // Writes during a clear are dropped; 0x00 is already cleared by cycle 4
        bus_a.clr_req = 1'b1;
        tick();
        bus_a.clr_req = 1'b0;
        chk("a_busy_after_req", 64'(bus_a.busy), 64'h1);
        chk("a_dbg_masked", 64'(bus_a.dbg_mem), 64'h0);
        tick();
        tick();
        bus_a.addr = 8'h80; bus_a.w_data = 8'h55; bus_a.w_en = 1'b1; #1;
        chk("a_mask_busy3", 64'(bus_a.r_data), 64'h0);
        tick();
        bus_a.addr = 8'h00; bus_a.w_data = 8'hC3;
        tick();
        bus_a.w_en = 1'b0;
        wait_idle_a(1'b1, n);
        chk("a_req_clear_len", 64'(n + 4), 64'd256);
        bus_a.addr = 8'h80; #1; chk("a_rd_80_dropped", 64'(bus_a.r_data), 64'h00);
        bus_a.addr = 8'h00; #1; chk("a_rd_00_dropped", 64'(bus_a.r_data), 64'h00);
        bus_a.addr = 8'h10; #1; chk("a_rd_10_cleared", 64'(bus_a.r_data), 64'h00);

        // Pre-load ends of the array, then simultaneous w_en and clr_req
        bus_a.w_en = 1'b1;
        bus_a.addr = 8'hFF; bus_a.w_data = 8'h99; tick();
        bus_a.addr = 8'h00; bus_a.w_data = 8'h11; tick();
        bus_a.w_en = 1'b0;
        chk("a_dbg_preload", 64'(bus_a.dbg_mem), 64'h0011);
        bus_a.addr = 8'hFF; #1; chk("a_rd_ff_preload", 64'(bus_a.r_data), 64'h99);
        bus_a.addr = 8'h05; bus_a.w_data = 8'h77; bus_a.w_en = 1'b1; bus_a.clr_req = 1'b1;
        tick();
        bus_a.w_en = 1'b0; bus_a.clr_req = 1'b0;
        chk("a_busy_simul", 64'(bus_a.busy), 64'h1);
        wait_idle_a(1'b0, n);
        chk("a_simul_clear_len", 64'(n), 64'd256);
        chk("a_rd_05_cleared", 64'(bus_a.r_data), 64'h00);
        bus_a.addr = 8'hFF; #1; chk("a_rd_ff_cleared", 64'(bus_a.r_data), 64'h00);
        chk("a_dbg_cleared", 64'(bus_a.dbg_mem), 64'h0);

        // Asynchronous reset during clear cycle 100 restarts the sequence
        bus_a.clr_req = 1'b1;
        tick();
        bus_a.clr_req = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        chk("a_busy_cycle100", 64'(bus_a.busy), 64'h1);
        #2;
        rst_a = 1'b1;
        #1;
        chk("a_busy_mid_reset", 64'(bus_a.busy), 64'h1);
        chk("a_rdata_mid_reset", 64'(bus_a.r_data), 64'h0);
        tick();
        rst_a = 1'b0;
        wait_idle_a(1'b0, n);
        chk("a_restart_clear_len", 64'(n), 64'd256);

        // 16x16 instance without clear-on-reset
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        chk("b_busy_after_reset", 64'(bus_b.busy), 64'h0);
        bus_b.w_en = 1'b1;
        bus_b.addr = 4'd3; bus_b.w_data = 16'hBEEF; tick();
        bus_b.addr = 4'd0; bus_b.w_data = 16'h1234; tick();
        bus_b.w_en = 1'b0;
        chk("b_dbg_tap3", 64'(bus_b.dbg_mem[63:48]), 64'hBEEF);
        chk("b_dbg_tap0", 64'(bus_b.dbg_mem[15:0]),  64'h1234);
        bus_b.addr = 4'd3; #1;
        chk("b_rd_3", 64'(bus_b.r_data), 64'hBEEF);
        bus_b.clr_req = 1'b1;
        tick();
        bus_b.clr_req = 1'b0;
        chk("b_busy_after_req", 64'(bus_b.busy), 64'h1);
        wait_idle_b(n);
        chk("b_clear_len", 64'(n), 64'd16);
        chk("b_dbg_cleared", bus_b.dbg_mem, 64'h0);

        // Reset mid-clear without clear-on-reset drops straight to idle
        bus_b.w_en = 1'b1; bus_b.addr = 4'd15; bus_b.w_data = 16'hCAFE; tick();
        bus_b.w_en = 1'b0;
        bus_b.clr_req = 1'b1; tick(); bus_b.clr_req = 1'b0;
        tick(); tick();
        #2;
        rst_b = 1'b1;
        #1;
        chk("b_busy_mid_reset", 64'(bus_b.busy), 64'h0);
        tick();
        rst_b = 1'b0;
        bus_b.addr = 4'd15; #1;
        chk("b_partial_clear_15", 64'(bus_b.r_data), 64'hCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
